// File: rtl/stall_ctrl_pkg.sv
// Shared types and constants for the pipeline stall controller.
// The perf counters sized here are only built when STALL_COUNTERS_EN is defined.
package stall_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    FLUSH    = 2'd2
  } state_t;

  localparam int WAIT_CNT_W = 8;
  localparam int HAZ_RUN_W  = 4;
  localparam int FLUSH_W    = 3;
  localparam int PERF_CNT_W = 32;

  // Control word loaded into ID-EXE on a bubble: every control bit cleared.
  localparam logic [15:0] NOP_CTRL = 16'h0000;

endpackage

// File: rtl/stall_event_counter.sv
// Event counter with enable and clear; sat=1 holds at all-ones, sat=0 wraps.
module stall_event_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic         sat,
  output logic [W-1:0] cnt
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en && !(sat && (&cnt_q))) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/pipeline_stall_controller.sv
// Per-stage freeze/flush/bubble control with memory timeout and hazard watchdog.
// Perf counters are built only when STALL_COUNTERS_EN is defined.
//   state    | meaning
//   RUN      | normal issue; branch flush and hazard stall evaluated
//   MEM_WAIT | MEM stage waiting on SRAM; everything frozen
//   FLUSH    | extra IF-ID flush cycles after a taken branch
module pipeline_stall_controller
  import stall_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES   = 1,
  parameter int MEM_TIMEOUT    = 64,
  parameter int MAX_HAZARD_RUN = 3
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        hazard_detected,
  input  logic        branch_taken,
  input  logic        mem_req,
  input  logic        mem_ready,
  output logic        freeze_if,
  output logic        flush_if,
  output logic        bubble_id,
  output logic        freeze_all,
  output logic        mem_timeout,
  output logic        hazard_deadlock,
  output logic [31:0] hazard_stall_cnt,
  output logic [31:0] mem_stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam logic [FLUSH_W-1:0] FLUSH_RELOAD = FLUSH_W'(FLUSH_CYCLES - 1);

  state_t                 state_q, state_d;
  logic [FLUSH_W-1:0]     flush_left_q, flush_left_d;
  logic                   mem_timeout_q, mem_timeout_d;
  logic                   deadlock_q, deadlock_d;
  logic [WAIT_CNT_W-1:0]  wait_cnt;
  logic [HAZ_RUN_W-1:0]   hazard_run;
  logic                   mem_wait, run_rules;
  logic                   frz_all, frz_if, fl_if, bub_id;
  logic                   hz_stall, hz_clr, br_acc;

  always_comb begin
    state_d      = state_q;
    flush_left_d = flush_left_q;
    mem_wait     = mem_req & ~mem_ready;
    run_rules    = 1'b0;
    frz_all      = 1'b0;
    frz_if       = 1'b0;
    fl_if        = 1'b0;
    bub_id       = 1'b0;
    hz_stall     = 1'b0;
    hz_clr       = 1'b0;
    br_acc       = 1'b0;

    case (state_q)
      RUN: begin
        if (mem_wait) begin
          frz_all = 1'b1;
          state_d = MEM_WAIT;
        end else begin
          run_rules = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (!mem_ready) begin
          frz_all = 1'b1;
        end else begin
          state_d   = RUN;
          run_rules = 1'b1;
        end
      end
      FLUSH: begin
        // A memory wait suspends the flush; the remaining count resumes after.
        if (mem_wait) begin
          frz_all = 1'b1;
        end else begin
          fl_if  = 1'b1;
          bub_id = 1'b1;
          if (branch_taken) begin
            br_acc       = 1'b1;
            flush_left_d = FLUSH_RELOAD;
            state_d      = (FLUSH_CYCLES > 1) ? FLUSH : RUN;
          end else if (flush_left_q <= FLUSH_W'(1)) begin
            flush_left_d = '0;
            state_d      = RUN;
          end else begin
            flush_left_d = flush_left_q - FLUSH_W'(1);
          end
        end
      end
      default: state_d = RUN;
    endcase

    if (run_rules) begin
      if (branch_taken) begin
        fl_if  = 1'b1;
        bub_id = 1'b1;
        br_acc = 1'b1;
        hz_clr = 1'b1;
        if (FLUSH_CYCLES > 1) begin
          state_d      = FLUSH;
          flush_left_d = FLUSH_RELOAD;
        end else begin
          state_d      = RUN;
          flush_left_d = '0;
        end
      end else if (hazard_detected) begin
        frz_if   = 1'b1;
        bub_id   = 1'b1;
        hz_stall = 1'b1;
      end else begin
        hz_clr = 1'b1;
      end
    end

    // Flags latch on the cycle the counter is about to reach its limit.
    mem_timeout_d = mem_timeout_q |
                    (frz_all && (wait_cnt == WAIT_CNT_W'(MEM_TIMEOUT - 1)));
    deadlock_d    = deadlock_q |
                    (hz_stall && (hazard_run == HAZ_RUN_W'(MAX_HAZARD_RUN - 1)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      flush_left_q  <= '0;
      mem_timeout_q <= 1'b0;
      deadlock_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      flush_left_q  <= flush_left_d;
      mem_timeout_q <= mem_timeout_d;
      deadlock_q    <= deadlock_d;
    end
  end

  stall_event_counter #(.W(WAIT_CNT_W)) u_wait_cnt (
    .clk(clk), .rst_n(rst_n), .clr(~frz_all), .en(frz_all), .sat(1'b1), .cnt(wait_cnt)
  );

  stall_event_counter #(.W(HAZ_RUN_W)) u_hazard_run (
    .clk(clk), .rst_n(rst_n), .clr(hz_clr), .en(hz_stall), .sat(1'b1), .cnt(hazard_run)
  );

  // Reset gates the Mealy outputs so they drop the instant rst_n falls.
  assign freeze_all      = rst_n & frz_all;
  assign freeze_if       = rst_n & frz_if;
  assign flush_if        = rst_n & fl_if;
  assign bubble_id       = rst_n & bub_id;
  assign mem_timeout     = mem_timeout_q;
  assign hazard_deadlock = deadlock_q;

`ifdef STALL_COUNTERS_EN
  stall_event_counter #(.W(PERF_CNT_W)) u_hazard_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(frz_if), .sat(1'b0), .cnt(hazard_stall_cnt)
  );
  stall_event_counter #(.W(PERF_CNT_W)) u_mem_stall_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(frz_all), .sat(1'b0), .cnt(mem_stall_cnt)
  );
  stall_event_counter #(.W(PERF_CNT_W)) u_flush_cnt (
    .clk(clk), .rst_n(rst_n), .clr(1'b0), .en(br_acc), .sat(1'b0), .cnt(flush_cnt)
  );
`else
  assign hazard_stall_cnt = '0;
  assign mem_stall_cnt    = '0;
  assign flush_cnt        = '0;
`endif

endmodule

// File: tb/tb_pipeline_stall_controller.sv
// Vector-table and scoreboard bench for pipeline_stall_controller.
// Counter checks follow STALL_COUNTERS_EN.
module tb_pipeline_stall_controller;

  logic clk = 1'b0;
  logic rst_n, hz, br, req, rdy;

  logic        freeze_if, flush_if, bubble_id, freeze_all, mem_timeout, hazard_deadlock;
  logic [31:0] hazard_stall_cnt, mem_stall_cnt, flush_cnt;
  logic        freeze_if2, flush_if2, bubble_id2, freeze_all2, mem_timeout2, hazard_deadlock2;
  logic [31:0] hazard_stall_cnt2, mem_stall_cnt2, flush_cnt2;

  always #5 clk = ~clk;

  pipeline_stall_controller #(.FLUSH_CYCLES(3), .MEM_TIMEOUT(4), .MAX_HAZARD_RUN(3)) dut (
    .clk(clk), .rst_n(rst_n), .hazard_detected(hz), .branch_taken(br),
    .mem_req(req), .mem_ready(rdy),
    .freeze_if(freeze_if), .flush_if(flush_if), .bubble_id(bubble_id),
    .freeze_all(freeze_all), .mem_timeout(mem_timeout), .hazard_deadlock(hazard_deadlock),
    .hazard_stall_cnt(hazard_stall_cnt), .mem_stall_cnt(mem_stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_stall_controller #(.FLUSH_CYCLES(2), .MEM_TIMEOUT(64), .MAX_HAZARD_RUN(3)) dut2 (
    .clk(clk), .rst_n(rst_n), .hazard_detected(hz), .branch_taken(br),
    .mem_req(req), .mem_ready(rdy),
    .freeze_if(freeze_if2), .flush_if(flush_if2), .bubble_id(bubble_id2),
    .freeze_all(freeze_all2), .mem_timeout(mem_timeout2), .hazard_deadlock(hazard_deadlock2),
    .hazard_stall_cnt(hazard_stall_cnt2), .mem_stall_cnt(mem_stall_cnt2), .flush_cnt(flush_cnt2)
  );

  typedef struct {
    logic       rst_n, hz, br, req, rdy;
    logic [5:0] exp;  // {freeze_if, flush_if, bubble_id, freeze_all, mem_timeout, hazard_deadlock}
  } vec_t;

  vec_t       vecs[$];
  logic [5:0] sb_q[$];
  int checks   = 0;
  int failures = 0;

  function automatic logic [5:0] outs();
    return {freeze_if, flush_if, bubble_id, freeze_all, mem_timeout, hazard_deadlock};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic add(input logic r, input logic h, input logic b, input logic q,
                     input logic y, input logic [5:0] e);
    vec_t v;
    v.rst_n = r; v.hz = h; v.br = b; v.req = q; v.rdy = y; v.exp = e;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic r, input logic h, input logic b, input logic q,
                       input logic y);
    rst_n = r; hz = h; br = b; req = q; rdy = y;
  endtask

  task automatic step(input logic r, input logic h, input logic b, input logic q,
                      input logic y);
    @(negedge clk);
    drive(r, h, b, q, y);
    #4;
  endtask

  int flush_seen;

  initial begin
    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);

    // reset with hazard held, then hazard runs of 2 and of 4
    add(0,1,0,0,0, 6'b000000);
    add(1,1,0,0,0, 6'b101000);
    add(1,1,0,0,0, 6'b101000);
    add(1,0,0,0,0, 6'b000000);
    add(1,1,0,0,0, 6'b101000);
    add(1,1,0,0,0, 6'b101000);
    add(1,1,0,0,0, 6'b101000);
    add(1,1,0,0,0, 6'b101001);
    add(1,0,0,0,0, 6'b000001);
    add(0,0,0,0,0, 6'b000000);
    // five wait cycles, timeout after the fourth, then ready
    add(1,0,0,1,0, 6'b000100);
    add(1,0,0,1,0, 6'b000100);
    add(1,0,0,1,0, 6'b000100);
    add(1,0,0,1,0, 6'b000100);
    add(1,0,0,1,0, 6'b000110);
    add(1,0,0,1,1, 6'b000010);
    add(1,0,0,0,0, 6'b000010);
    add(0,0,0,0,0, 6'b000000);
    // branch beats hazard; FLUSH ignores hazard for three cycles total
    add(1,1,1,0,0, 6'b011000);
    add(1,1,0,0,0, 6'b011000);
    add(1,1,0,0,0, 6'b011000);
    add(1,1,0,0,0, 6'b101000);
    add(1,0,0,0,0, 6'b000000);
    // memory wait interrupts a flush, which then resumes
    add(1,0,1,0,0, 6'b011000);
    add(1,0,0,0,0, 6'b011000);
    add(1,0,0,1,0, 6'b000100);
    add(1,0,0,1,0, 6'b000100);
    add(1,0,0,1,1, 6'b011000);
    add(1,0,0,0,0, 6'b000000);
    // branch/hazard ignored during wait; branch on ready cycle; reload in FLUSH
    add(1,1,1,1,0, 6'b000100);
    add(1,0,1,1,1, 6'b011000);
    add(1,0,0,0,0, 6'b011000);
    add(1,0,1,0,0, 6'b011000);
    add(1,0,0,0,0, 6'b011000);
    add(1,0,0,0,0, 6'b011000);
    add(1,0,0,0,0, 6'b000000);

    foreach (vecs[i]) begin
      @(negedge clk);
      drive(vecs[i].rst_n, vecs[i].hz, vecs[i].br, vecs[i].req, vecs[i].rdy);
      sb_q.push_back(vecs[i].exp);
      #4;
      check($sformatf("vec%0d", i), 32'(outs()), 32'(sb_q.pop_front()));
    end

    // perf counters: 5 wait cycles, 2 hazard stalls, 1 branch
    step(0,0,0,0,0);
    repeat (5) step(1,0,0,1,0);
    step(1,0,0,1,1);
    repeat (2) step(1,1,0,0,0);
    step(1,0,1,0,0);
    repeat (3) step(1,0,0,0,0);
`ifdef STALL_COUNTERS_EN
    check("mem_stall_cnt", mem_stall_cnt, 32'd5);
    check("hazard_stall_cnt", hazard_stall_cnt, 32'd2);
    check("flush_cnt", flush_cnt, 32'd1);
`else
    check("mem_stall_cnt_tied", mem_stall_cnt, 32'd0);
    check("hazard_stall_cnt_tied", hazard_stall_cnt, 32'd0);
    check("flush_cnt_tied", flush_cnt, 32'd0);
`endif

    // FLUSH_CYCLES=2 instance: branch with hazard gives exactly two flush cycles
    step(0,0,0,0,0);
    flush_seen = 0;
    step(1,1,1,0,0);
    check("f2_cyc1", {29'd0, freeze_if2, flush_if2, bubble_id2}, 32'b011);
    flush_seen += int'(flush_if2);
    step(1,1,0,0,0);
    check("f2_cyc2", {29'd0, freeze_if2, flush_if2, bubble_id2}, 32'b011);
    flush_seen += int'(flush_if2);
    step(1,1,0,0,0);
    check("f2_back_in_run", {29'd0, freeze_if2, flush_if2, bubble_id2}, 32'b101);
    flush_seen += int'(flush_if2);
    check("f2_flush_total", 32'(flush_seen), 32'd2);

    // asynchronous reset in the middle of a timed-out memory stall
    step(0,0,0,0,0);
    repeat (5) step(1,0,0,1,0);
    check("pre_reset_stall", 32'(outs()), 32'b000110);
    #2 rst_n = 1'b0;
    #1 check("async_reset_outs", 32'(outs()), 32'd0);
    step(1,1,0,0,0);
    check("after_reset_run", 32'(outs()), 32'b101000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
